// File: rtl/xor_accum_pkg.sv
// Shared constants for the XOR accumulator controller: state encoding and word width.
package xor_accum_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/xor32.sv
// 32-bit bitwise XOR datapath element, shared by the accumulator controller.
module xor32
  import xor_accum_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  output logic [WORD_W-1:0] y_o
);

  assign y_o = a_i ^ b_i;

endmodule

// File: rtl/xor_accum_ctrl.sv
// Job sequencer folding a stream of words into a 32-bit XOR checksum via one xor32.
// Optional build macro XOR_ACCUM_ROTATE_EN: rotate the accumulator left by 1 before each fold.
module xor_accum_ctrl
  import xor_accum_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [WORD_W-1:0] seed,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] result,
  output logic [LEN_W-1:0]  count
);

  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] result_q, result_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [WORD_W-1:0] acc_pre;
  logic [WORD_W-1:0] xor_y;
  logic              hs;
  logic              last_hs;

`ifdef XOR_ACCUM_ROTATE_EN
  assign acc_pre = {acc_q[WORD_W-2:0], acc_q[WORD_W-1]};
`else
  assign acc_pre = acc_q;
`endif

  xor32 u_xor32 (
    .a_i (acc_pre),
    .b_i (in_data),
    .y_o (xor_y)
  );

  // A word arriving together with abort is dropped.
  assign hs      = (state_q == ST_ACCUM) && in_valid && !abort;
  assign last_hs = hs && (rem_q == LEN_W'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (len != '0) ? ST_ACCUM : ST_DONE;
        end
      end
      ST_ACCUM: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (last_hs) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register only
  always_comb begin
    in_ready = (state_q == ST_ACCUM);
    busy     = (state_q == ST_ACCUM) || (state_q == ST_DONE);
    done     = (state_q == ST_DONE);
  end

  // Result is loaded on the edge entering DONE so it is valid alongside done.
  always_comb begin
    acc_d    = acc_q;
    result_d = result_q;
    rem_d    = rem_q;
    count_d  = count_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = seed;
          rem_d   = len;
          count_d = '0;
          if (len == '0) begin
            result_d = seed;
          end
        end
      end
      ST_ACCUM: begin
        if (hs) begin
          acc_d   = xor_y;
          rem_d   = rem_q - LEN_W'(1);
          count_d = count_q + LEN_W'(1);
          if (last_hs) begin
            result_d = xor_y;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      result_q <= '0;
      rem_q    <= '0;
      count_q  <= '0;
    end else begin
      acc_q    <= acc_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      count_q  <= count_d;
    end
  end

  assign result = result_q;
  assign count  = count_q;

endmodule

// File: tb/tb_xor_accum_ctrl.sv
// Directed self-checking bench for xor_accum_ctrl (honours XOR_ACCUM_ROTATE_EN for expected values).
module tb_xor_accum_ctrl;

  localparam int LEN_W = 8;

  logic              clk;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [31:0]       seed;
  logic              abort;
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic [31:0]       result;
  logic [LEN_W-1:0]  count;

  int checks;
  int failures;

`ifdef XOR_ACCUM_ROTATE_EN
  localparam logic [31:0] EXP_STREAM = 32'hD0099445;
  localparam logic [31:0] EXP_GAP    = 32'h00000000;
  localparam logic [31:0] EXP_RST    = 32'h00000000;
`else
  localparam logic [31:0] EXP_STREAM = 32'hE23BA677;
  localparam logic [31:0] EXP_GAP    = 32'hFFFFFFFF;
  localparam logic [31:0] EXP_RST    = 32'h00000003;
`endif

  xor_accum_ctrl #(.LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .seed     (seed),
    .abort    (abort),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%08h", name, act);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; len = 0; seed = 0; abort = 0; in_valid = 0; in_data = 0;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    rst = 1'b0;
    step();
  endtask

  task automatic test_stream();
    logic [31:0] words [3];
    words[0] = 32'h0F0F0F0F; words[1] = 32'hFF00FF00; words[2] = 32'h12345678;
    start = 1; len = 3; seed = 32'h0;
    step();
    start = 0;
    chk("stream_in_ready", 32'(in_ready), 32'd1);
    chk("stream_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = words[i];
      step();
      if (i < 2) chk("stream_no_early_done", 32'(done), 32'd0);
    end
    in_valid = 0;
    chk("stream_done", 32'(done), 32'd1);
    chk("stream_result", result, EXP_STREAM);
    chk("stream_count", 32'(count), 32'd3);
    chk("stream_ready_low_in_done", 32'(in_ready), 32'd0);
    step();
    chk("stream_done_pulse", 32'(done), 32'd0);
    chk("stream_idle", 32'(busy), 32'd0);
    chk("stream_result_hold", result, EXP_STREAM);
  endtask

  task automatic test_len_zero();
    start = 1; len = 0; seed = 32'hDEADBEEF;
    step();
    start = 0;
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_result", result, 32'hDEADBEEF);
    chk("len0_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("len0_done_pulse", 32'(done), 32'd0);
    chk("len0_in_ready_after", 32'(in_ready), 32'd0);
  endtask

  task automatic test_gaps();
    start = 1; len = 2; seed = 32'h0;
    step();
    start = 0;
    in_valid = 1; in_data = 32'hAAAAAAAA;
    step();
    in_valid = 0; in_data = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gap_no_done", 32'(done), 32'd0);
      chk("gap_ready", 32'(in_ready), 32'd1);
    end
    chk("gap_count", 32'(count), 32'd1);
    in_valid = 1; in_data = 32'h55555555;
    step();
    in_valid = 0;
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_result", result, EXP_GAP);
    step();
  endtask

  task automatic test_abort();
    start = 1; len = 4; seed = 32'h00001234;
    step();
    start = 0;
    in_valid = 1; in_data = 32'h00000001;
    step();
    in_valid = 0; start = 1; len = 1; seed = 32'hCAFEF00D;
    step();
    start = 0;
    chk("abort_start_ignored_busy", 32'(busy), 32'd1);
    chk("abort_start_ignored_count", 32'(count), 32'd1);
    abort = 1; in_valid = 1; in_data = 32'h00000099;
    step();
    abort = 0; in_valid = 0;
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_count", 32'(count), 32'd1);
    chk("abort_result_kept", result, EXP_GAP);
    step();
    chk("abort_still_no_done", 32'(done), 32'd0);
  endtask

  task automatic test_reset_midjob();
    start = 1; len = 3; seed = 32'h5;
    step();
    start = 0;
    in_valid = 1; in_data = 32'h00000007;
    step();
    in_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_result", result, 32'h0);
    chk("midrst_count", 32'(count), 32'd0);
    step();
    rst = 1'b0;
    step();
    start = 1; len = 1; seed = 32'h1;
    step();
    start = 0;
    in_valid = 1; in_data = 32'h2;
    step();
    in_valid = 0;
    chk("midrst_job_done", 32'(done), 32'd1);
    chk("midrst_job_result", result, EXP_RST);
    chk("midrst_job_count", 32'(count), 32'd1);
    step();
  endtask

`ifdef XOR_ACCUM_ROTATE_EN
  task automatic test_rotate();
    start = 1; len = 1; seed = 32'h80000000;
    step();
    start = 0;
    in_valid = 1; in_data = 32'h0;
    step();
    in_valid = 0;
    chk("rotate_done", 32'(done), 32'd1);
    chk("rotate_result", result, 32'h00000001);
    step();
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_len_zero();
    test_gaps();
    test_abort();
    test_reset_midjob();
`ifdef XOR_ACCUM_ROTATE_EN
    test_rotate();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
